// File: rtl/flag_branch_unit_pkg.sv
// rtl/flag_branch_unit_pkg.sv - shared types for the flag/branch unit (opcodes, conditions, flags, FSM states)
package flag_branch_unit_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        OP_ADD    = 3'b000,
        OP_SUB    = 3'b001,
        OP_XOR    = 3'b010,
        OP_RED    = 3'b011,
        OP_SLL    = 3'b100,
        OP_SRA    = 3'b101,
        OP_ROR    = 3'b110,
        OP_PADDSB = 3'b111
    } opcode_e;

    typedef enum logic [2:0] {
        BR_NE  = 3'b000,
        BR_EQ  = 3'b001,
        BR_GT  = 3'b010,
        BR_LT  = 3'b011,
        BR_GTE = 3'b100,
        BR_LTE = 3'b101,
        BR_OV  = 3'b110,
        BR_AL  = 3'b111
    } br_cond_e;

    typedef struct packed {
        logic z;
        logic v;
        logic n;
    } flags_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HOLD = 2'b01,
        ST_RESP = 2'b10
    } state_e;

endpackage

// File: rtl/flag_branch_unit_br_cond_eval.sv
// rtl/flag_branch_unit_br_cond_eval.sv - combinational branch condition decode against {Z,V,N}
module br_cond_eval
    import flag_branch_unit_pkg::*;
(
    input  flags_t     flags,
    input  logic [2:0] br_cond,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (br_cond_e'(br_cond))
            BR_NE:   taken = ~flags.z;
            BR_EQ:   taken = flags.z;
            BR_GT:   taken = ~flags.z & ~flags.n;
            BR_LT:   taken = flags.n;
            BR_GTE:  taken = flags.z | ~flags.n;
            BR_LTE:  taken = flags.z | flags.n;
            BR_OV:   taken = flags.v;
            BR_AL:   taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_branch_unit.sv
// rtl/flag_branch_unit.sv - ALU flag register and branch resolution FSM
// FLAG_BYPASS_EN: forward a same-cycle flag write into branch evaluation (no HOLD state).
module flag_branch_unit #(
    parameter int DATA_W = flag_branch_unit_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_vld,
    input  logic [2:0]        opcode,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [DATA_W-1:0] result,
    input  logic              flush,
    input  logic              br_vld,
    input  logic [2:0]        br_cond,
    output logic [2:0]        flags,
    output logic              br_busy,
    output logic              br_done,
    output logic              br_taken
);
    import flag_branch_unit_pkg::*;

    localparam int MSB = DATA_W - 1;

    flags_t     flags_q;
    flags_t     flags_nxt;
    flags_t     eval_flags;
    state_e     state;
    logic [2:0] eval_cond;
    logic       flag_wr;
    logic       taken;
    logic       sum_msb;
    logic       diff_msb;

    assign flag_wr  = alu_vld & ~flush;
    // Overflow is judged on the unsaturated result, not on the result input.
    assign sum_msb  = 1'((A + B) >> MSB);
    assign diff_msb = 1'((A - B) >> MSB);

    always_comb begin
        flags_nxt = flags_q;
        if (flag_wr) begin
            case (opcode_e'(opcode))
                OP_ADD: begin
                    flags_nxt.z = (result == '0);
                    flags_nxt.n = result[MSB];
                    flags_nxt.v = (A[MSB] == B[MSB]) && (sum_msb != A[MSB]);
                end
                OP_SUB: begin
                    flags_nxt.z = (result == '0);
                    flags_nxt.n = result[MSB];
                    flags_nxt.v = (A[MSB] != B[MSB]) && (diff_msb != A[MSB]);
                end
                OP_XOR, OP_SLL, OP_SRA, OP_ROR: flags_nxt.z = (result == '0);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) flags_q <= '0;
        else     flags_q <= flags_nxt;
    end

`ifdef FLAG_BYPASS_EN
    assign eval_flags = flags_nxt;
    assign eval_cond  = br_cond;
`else
    logic [2:0] cond_q;
    assign eval_flags = flags_q;
    assign eval_cond  = (state == ST_HOLD) ? cond_q : br_cond;
`endif

    br_cond_eval u_br_cond_eval (
        .flags   (eval_flags),
        .br_cond (eval_cond),
        .taken   (taken)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            br_done  <= 1'b0;
            br_taken <= 1'b0;
`ifndef FLAG_BYPASS_EN
            cond_q   <= 3'b000;
`endif
        end else begin
            br_done  <= 1'b0;
            br_taken <= 1'b0;
            if (flush) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (br_vld) begin
`ifdef FLAG_BYPASS_EN
                            state    <= ST_RESP;
                            br_done  <= 1'b1;
                            br_taken <= taken;
`else
                            cond_q <= br_cond;
                            // A write this cycle would race the capture; wait for it to land.
                            if (flag_wr) begin
                                state <= ST_HOLD;
                            end else begin
                                state    <= ST_RESP;
                                br_done  <= 1'b1;
                                br_taken <= taken;
                            end
`endif
                        end
                    end
                    ST_HOLD: begin
                        state    <= ST_RESP;
                        br_done  <= 1'b1;
                        br_taken <= taken;
                    end
                    ST_RESP: state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign flags   = flags_q;
    assign br_busy = (state != ST_IDLE);

endmodule
